// File: rtl/event_request_unit.sv
// Sticky rising-edge event capture with a fixed-priority req/ack
// request port and a sticky overflow flag.
module event_request_unit #(
  parameter int NUM_SRC = 3,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               irq_ack,
  input  logic               ovf_clr,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               overflow
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] req_vec;
  logic [ID_W-1:0]    sel;
  logic               ack_fire;
  logic               ovf_set;

  always_comb begin
    rise     = src_in & ~prev;
    ack_fire = (state == REQ) && irq_ack;
    req_vec  = pending & ~mask;
    clr      = '0;
    sel      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_fire && irq_id == ID_W'(i))
        clr[i] = 1'b1;
    end
    // Scan downward so the lowest index wins.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_vec[i])
        sel = ID_W'(i);
    end
    ovf_set = |(rise & pending & ~clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      prev     <= src_in;
      pending  <= rise | (pending & ~clr);
      overflow <= ovf_set | (overflow & ~ovf_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_vec) begin
            state   <= REQ;
            irq_req <= 1'b1;
            irq_id  <= sel;
          end
        end
        REQ: begin
          if (ack_fire) begin
            state   <= GAP;
            irq_req <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_request_unit.sv
// Directed table-driven bench for event_request_unit plus
// hand-written reset corner cases.
module tb_event_request_unit;

  logic       clk;
  logic       rst_n;
  logic [2:0] src_in;
  logic [2:0] mask;
  logic       irq_ack;
  logic       ovf_clr;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [2:0] pending;
  logic       overflow;

  int checks;
  int errors;

  typedef struct {
    logic [2:0] src;
    logic [2:0] msk;
    logic       ack;
    logic       clr;
    logic       req;
    logic [1:0] id;
    logic [2:0] pend;
    logic       ovf;
  } vec_t;

  vec_t v[$];

  event_request_unit #(.NUM_SRC(3), .ID_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_in   (src_in),
    .mask     (mask),
    .irq_ack  (irq_ack),
    .ovf_clr  (ovf_clr),
    .irq_req  (irq_req),
    .irq_id   (irq_id),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] s, input logic [2:0] m,
                     input logic a, input logic c, input logic r,
                     input logic [1:0] i, input logic [2:0] p,
                     input logic o);
    vec_t t;
    t.src = s; t.msk = m; t.ack = a; t.clr = c;
    t.req = r; t.id = i; t.pend = p; t.ovf = o;
    v.push_back(t);
  endtask

  task automatic drive(input logic [2:0] s, input logic [2:0] m,
                       input logic a, input logic c);
    @(negedge clk);
    src_in  = s;
    mask    = m;
    irq_ack = a;
    ovf_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    src_in  = 3'b000;
    mask    = 3'b000;
    irq_ack = 1'b0;
    ovf_clr = 1'b0;
    #1;
    chk("rst_req",  32'(irq_req),  32'd0);
    chk("rst_id",   32'(irq_id),   32'd0);
    chk("rst_pend", 32'(pending),  32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);

    //  src     mask    ack  clr  req  id  pend    ovf
    // single event on source 1
    add(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0);
    add(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0);
    add(3'b010, 3'b000, 0, 0, 0, 0, 3'b010, 0);
    add(3'b000, 3'b000, 0, 0, 1, 1, 3'b010, 0);
    add(3'b000, 3'b000, 0, 0, 1, 1, 3'b010, 0);
    add(3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 0);
    add(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0);
    add(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0);
    // simultaneous 0 and 2, priority and GAP
    add(3'b101, 3'b000, 0, 0, 0, 0, 3'b101, 0);
    add(3'b101, 3'b000, 0, 0, 1, 0, 3'b101, 0);
    add(3'b000, 3'b000, 1, 0, 0, 0, 3'b100, 0);
    add(3'b000, 3'b000, 0, 0, 0, 0, 3'b100, 0);
    add(3'b000, 3'b000, 0, 0, 1, 2, 3'b100, 0);
    add(3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 0);
    add(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0);
    // masked source latches, request only after unmask
    add(3'b001, 3'b001, 0, 0, 0, 0, 3'b001, 0);
    add(3'b000, 3'b001, 0, 0, 0, 0, 3'b001, 0);
    add(3'b000, 3'b001, 0, 0, 0, 0, 3'b001, 0);
    add(3'b000, 3'b001, 0, 0, 0, 0, 3'b001, 0);
    add(3'b000, 3'b001, 0, 0, 0, 0, 3'b001, 0);
    add(3'b000, 3'b001, 1, 0, 0, 0, 3'b001, 0);
    add(3'b000, 3'b000, 0, 0, 1, 0, 3'b001, 0);
    add(3'b000, 3'b001, 0, 0, 1, 0, 3'b001, 0);
    add(3'b000, 3'b001, 1, 0, 0, 0, 3'b000, 0);
    add(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0);
    // overflow, clear, set-wins, edge+ack on same bit
    add(3'b100, 3'b000, 0, 0, 0, 0, 3'b100, 0);
    add(3'b000, 3'b000, 0, 0, 1, 2, 3'b100, 0);
    add(3'b100, 3'b000, 0, 0, 1, 2, 3'b100, 1);
    add(3'b000, 3'b000, 0, 1, 1, 2, 3'b100, 0);
    add(3'b100, 3'b000, 1, 0, 0, 0, 3'b100, 0);
    add(3'b000, 3'b000, 0, 0, 0, 0, 3'b100, 0);
    add(3'b000, 3'b000, 0, 0, 1, 2, 3'b100, 0);
    add(3'b100, 3'b000, 0, 1, 1, 2, 3'b100, 1);
    add(3'b000, 3'b000, 0, 1, 1, 2, 3'b100, 0);
    add(3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 0);
    add(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0);
    // ack held high with three queued events
    add(3'b111, 3'b000, 1, 0, 0, 0, 3'b111, 0);
    add(3'b000, 3'b000, 1, 0, 1, 0, 3'b111, 0);
    add(3'b000, 3'b000, 1, 0, 0, 0, 3'b110, 0);
    add(3'b000, 3'b000, 1, 0, 0, 0, 3'b110, 0);
    add(3'b000, 3'b000, 1, 0, 1, 1, 3'b110, 0);
    add(3'b000, 3'b000, 1, 0, 0, 0, 3'b100, 0);
    add(3'b000, 3'b000, 1, 0, 0, 0, 3'b100, 0);
    add(3'b000, 3'b000, 1, 0, 1, 2, 3'b100, 0);
    add(3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 0);
    add(3'b000, 3'b000, 1, 0, 0, 0, 3'b000, 0);
    add(3'b000, 3'b000, 0, 0, 0, 0, 3'b000, 0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (v[k]) begin
      drive(v[k].src, v[k].msk, v[k].ack, v[k].clr);
      chk($sformatf("v%0d_req", k), 32'(irq_req), 32'(v[k].req));
      chk($sformatf("v%0d_pend", k), 32'(pending), 32'(v[k].pend));
      chk($sformatf("v%0d_ovf", k), 32'(overflow), 32'(v[k].ovf));
      if (v[k].req)
        chk($sformatf("v%0d_id", k), 32'(irq_id), 32'(v[k].id));
    end

    // source high across reset release: one event only
    @(negedge clk);
    rst_n  = 1'b0;
    src_in = 3'b001;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_pend1", 32'(pending), 32'b001);
    chk("hold_req1",  32'(irq_req), 32'd0);
    drive(3'b001, 3'b000, 0, 0);
    chk("hold_req2",  32'(irq_req), 32'd1);
    chk("hold_id2",   32'(irq_id),  32'd0);
    for (int n = 0; n < 4; n++)
      drive(3'b001, 3'b000, 0, 0);
    chk("hold_pend3", 32'(pending),  32'b001);
    chk("hold_ovf3",  32'(overflow), 32'd0);
    chk("hold_req3",  32'(irq_req),  32'd1);
    drive(3'b000, 3'b000, 0, 0);
    drive(3'b001, 3'b000, 0, 0);
    chk("pre_ovf", 32'(overflow), 32'd1);

    // asynchronous reset while in REQ
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req",  32'(irq_req),  32'd0);
    chk("arst_pend", 32'(pending),  32'd0);
    chk("arst_ovf",  32'(overflow), 32'd0);
    src_in = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b000, 3'b000, 0, 0);
    chk("post_req", 32'(irq_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
